// File: rtl/ctn_pkg.sv
// ----------------------------------------------------------------------------
// ctn_pkg
// Shared constants and types for the control_to_neuron serial frame loader.
//   N_NEURONS  : phase words per frame (5x3 grid, row-major)
//   PHASE_W    : bits per phase word
//   FRAME_BITS : bits per frame (derived, not overridable)
//   CNT_W      : width of the in-frame bit counter
// A frame is an ascending vector [0:FRAME_BITS-1]; word k occupies
// bits [PHASE_W*k : PHASE_W*k+PHASE_W-1] with its MSB at the lower index.
// ----------------------------------------------------------------------------
package ctn_pkg;

    localparam int N_NEURONS  = 15;
    localparam int PHASE_W    = 4;
    localparam int FRAME_BITS = N_NEURONS * PHASE_W;
    localparam int CNT_W      = $clog2(FRAME_BITS);

    // Counter value on the edge that captures the last bit of a frame.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BITS - 1);

    typedef logic [PHASE_W-1:0]    phase_t;
    typedef logic [0:FRAME_BITS-1] frame_t;

    // Modulo-FRAME_BITS increment of the bit counter.
    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt);
        logic [CNT_W-1:0] nxt;
        if (cnt == CNT_LAST) begin
            nxt = {CNT_W{1'b0}};
        end else begin
            nxt = cnt + CNT_W'(1);
        end
        return nxt;
    endfunction

    // Extract phase word k (0 = row 0 col 0) from a frame.
    function automatic phase_t frame_word(input frame_t frame, input int k);
        return frame[k*PHASE_W +: PHASE_W];
    endfunction

endpackage

// File: rtl/ctn_if.sv
// ----------------------------------------------------------------------------
// ctn_if
// Bus between the serial controller and the neuron-array loader.
//   bit_in  : serial phase data, one bit per clock, MSB of each word first
//   phi_out : assembled phase frame [0:FRAME_BITS-1]
//   num     : one-clock frame-complete strobe
// Modports: master = controller side (drives bit_in),
//           slave  = loader side (drives phi_out and num).
// ----------------------------------------------------------------------------
interface ctn_if;
    import ctn_pkg::*;

    logic   bit_in;
    frame_t phi_out;
    logic   num;

    modport master (output bit_in, input phi_out, input num);
    modport slave  (input bit_in, output phi_out, output num);

endinterface

// File: rtl/ctn_deser.sv
// ----------------------------------------------------------------------------
// ctn_deser
// Shift register plus modulo-FRAME_BITS bit counter.
//   clk     : rising-edge clock
//   rst_n   : synchronous active-low reset
//   bit_in  : serial data, shifted in every clock (X/Z passed through as-is)
//   frame_o : current shift-register contents; the oldest bit sits at index 0
//   done_o  : high while the counter is at its last value, i.e. the coming
//             edge captures the final bit of the current frame
// ----------------------------------------------------------------------------
module ctn_deser
    import ctn_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   bit_in,
    output frame_t frame_o,
    output logic   done_o
);

    frame_t           shift_q;
    frame_t           shift_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next-state: shift toward index 0 so the first bit of a frame ends at bit 0.
    always_comb begin
        shift_d = {shift_q[1:FRAME_BITS-1], bit_in};
        cnt_d   = cnt_next(cnt_q);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift_q <= {FRAME_BITS{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    assign frame_o = shift_q;
    assign done_o  = (cnt_q == CNT_LAST);

endmodule

// File: rtl/control_to_neuron.sv
// ----------------------------------------------------------------------------
// control_to_neuron
// Serial-to-parallel loader for the oscillatory neural network array.
// Collects FRAME_BITS serial bits into a frame of N_NEURONS phase words and
// strobes num for one clock after each completed frame (frames back-to-back,
// no gap cycles).
//   clk    : rising-edge clock, single domain
//   rst_n  : synchronous active-low reset; discards any partial frame
//   bus    : ctn_if.slave (bit_in in; phi_out, num out)
// Build option CTN_SHADOW_EN:
//   defined   -> phi_out is a holding register loaded at frame end and stable
//                for the whole following frame
//   undefined -> phi_out follows the shift register every clock and holds a
//                valid frame only in the cycle num=1
// ----------------------------------------------------------------------------
module control_to_neuron
    import ctn_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    ctn_if.slave  bus
);

    frame_t frame_s;
    logic   done_s;
    logic   num_q;
    logic   num_d;

    ctn_deser u_deser (
        .clk     (clk),
        .rst_n   (rst_n),
        .bit_in  (bus.bit_in),
        .frame_o (frame_s),
        .done_o  (done_s)
    );

    // Strobe is set by the edge that captures the last bit of a frame.
    always_comb begin
        num_d = done_s;
    end

    // Frame-complete strobe register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            num_q <= 1'b0;
        end else begin
            num_q <= num_d;
        end
    end

    assign bus.num = num_q;

`ifdef CTN_SHADOW_EN
    frame_t phi_q;
    frame_t phi_d;

    // Load the finished frame; it must include the bit arriving on this edge,
    // which is not yet inside the shift register.
    always_comb begin
        if (done_s) begin
            phi_d = {frame_s[1:FRAME_BITS-1], bus.bit_in};
        end else begin
            phi_d = phi_q;
        end
    end

    // Holding register for the presented frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phi_q <= {FRAME_BITS{1'b0}};
        end else begin
            phi_q <= phi_d;
        end
    end

    assign bus.phi_out = phi_q;
`else
    assign bus.phi_out = frame_s;
`endif

endmodule

// File: tb/tb_control_to_neuron.sv
// ----------------------------------------------------------------------------
// tb_control_to_neuron
// Self-checking bench for control_to_neuron: directed frame table, reset
// corner cases and randomized bits with sporadic resets, all compared every
// cycle against a queue-based model of the last bits received since reset.
// ----------------------------------------------------------------------------
module tb_control_to_neuron;
    import ctn_pkg::*;

    typedef struct {
        frame_t stream;   // stream[i] is sent on clock i of the frame
        frame_t exp_phi;  // frame expected on phi_out when num pulses
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;

    ctn_if bus ();

    control_to_neuron dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int     total = 0;
    int     bad   = 0;
    logic   hist_q[$];      // up to FRAME_BITS most recent bits since reset
    int     n_bits = 0;     // bits accepted since reset
    frame_t last_frame = '0;
    int     pulses = 0;
    vec_t   vecs[6];

    // Expected shift contents: the most recent bits right-aligned at the top index.
    function automatic frame_t exp_window();
        frame_t e;
        int off;
        e = '0;
        off = FRAME_BITS - hist_q.size();
        for (int i = 0; i < FRAME_BITS; i++) begin
            if (i >= off) e[i] = hist_q[i - off];
        end
        return e;
    endfunction

    task automatic check_phi(input string nm, input frame_t got, input frame_t exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic check_bit(input string nm, input logic got, input logic exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic check_int(input string nm, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, got, exp, $time);
        end
    endtask

    // One clock: drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic tick(input logic b, input logic rn);
        logic exp_num;
        @(negedge clk);
        bus.bit_in = b;
        rst_n      = rn;
        @(posedge clk);
        #1;
        if (!rn) begin
            hist_q.delete();
            n_bits     = 0;
            last_frame = '0;
            exp_num    = 1'b0;
        end else begin
            hist_q.push_back(b);
            if (hist_q.size() > FRAME_BITS) void'(hist_q.pop_front());
            n_bits++;
            exp_num = ((n_bits % FRAME_BITS) == 0);
            if (exp_num) last_frame = exp_window();
        end
        if (bus.num === 1'b1) pulses++;
        check_bit("num", bus.num, exp_num);
`ifdef CTN_SHADOW_EN
        check_phi("phi_hold", bus.phi_out, last_frame);
`else
        check_phi("phi_shift", bus.phi_out, exp_window());
`endif
    endtask

    initial begin
        // Frame table, applied back-to-back with no gap cycles.
        vecs[0].stream = 60'hFFFF_0FF0_FF0F_FFF; vecs[0].exp_phi = 60'hFFFF_0FF0_FF0F_FFF;
        vecs[1].stream = 60'h800_0000_0000_0000; vecs[1].exp_phi = 60'h800_0000_0000_0000;
        vecs[2].stream = 60'hFFF_FFFF_FFFF_FFFF; vecs[2].exp_phi = 60'hFFF_FFFF_FFFF_FFFF;
        vecs[3].stream = 60'h000_0000_0000_0000; vecs[3].exp_phi = 60'h000_0000_0000_0000;
        vecs[4].stream = 60'h012_3456_789A_BCDE; vecs[4].exp_phi = 60'h012_3456_789A_BCDE;
        vecs[5].stream = 60'h000_0000_0000_0001; vecs[5].exp_phi = 60'h000_0000_0000_0001;

        rst_n      = 1'b0;
        bus.bit_in = 1'b0;

        // Reset held for three clocks.
        repeat (3) tick(1'b1, 1'b0);
        check_phi("rst_phi", bus.phi_out, '0);
        check_bit("rst_num", bus.num, 1'b0);

        // 59 bits after release: no strobe yet.
        pulses = 0;
        for (int i = 0; i < FRAME_BITS - 1; i++) tick(1'($urandom_range(0, 1)), 1'b1);
        check_int("no_num_59", pulses, 0);
        tick(1'b0, 1'b0);

        // Table of frames, back-to-back.
        pulses = 0;
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < FRAME_BITS; i++) tick(vecs[r].stream[i], 1'b1);
            check_bit("tbl_num", bus.num, 1'b1);
            check_phi("tbl_phi", bus.phi_out, vecs[r].exp_phi);
            check_int("tbl_pulses", pulses, r + 1);
        end
        check_int("word0", int'(frame_word(vecs[4].exp_phi, 0)), 0);

        // Mid-frame reset: 30 bits, one reset clock, then the canonical frame.
        for (int i = 0; i < 30; i++) tick(1'($urandom_range(0, 1)), 1'b1);
        tick(1'b1, 1'b0);
        check_phi("midrst_phi", bus.phi_out, '0);
        pulses = 0;
        for (int i = 0; i < FRAME_BITS; i++) begin
            tick(vecs[0].stream[i], 1'b1);
            if (i == FRAME_BITS - 2) check_int("midrst_early", pulses, 0);
        end
        check_int("midrst_pulses", pulses, 1);
        check_bit("midrst_num", bus.num, 1'b1);
        check_phi("midrst_phi_frame", bus.phi_out, 60'hFFFF_0FF0_FF0F_FFF);

        // One more bit: strobe drops; phi_out either holds or starts shifting.
        tick(1'b1, 1'b1);
        check_bit("num_one_clk", bus.num, 1'b0);

        // Randomized bits with occasional resets.
        for (int i = 0; i < 900; i++) begin
            tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 149) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
